// File: rtl/row_pair_packer.sv
// row_pair_packer
//   Packs an 8-bit pixel stream into 24-bit words (three pixels per word,
//   first pixel in the MSB byte). Each row is stored in one of three word
//   buffers that are used in rotation. After a row ends, the just-written row
//   (m stream) and the row before it (s stream) are replayed together as one
//   burst of N_W words.
// Ports
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_h_aync, i_v_aync       row valid / frame valid
//   i_data                   pixel, valid while i_h_aync is high
//   o_h_aync_m/_s            burst word valid (identical)
//   o_v_aync_m/_s            frame valid for the burst streams (identical)
//   o_data_m/_s              current-row / previous-row packed words
//   o_remainder_signal_m/_s  partial last word of a row (identical)
module row_pair_packer #(
  parameter int P_IMAGE_WIDTH  = 256,
  parameter int P_IMAGE_HEIGHT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_h_aync,
  input  logic        i_v_aync,
  input  logic [7:0]  i_data,
  output logic        o_h_aync_m,
  output logic        o_h_aync_s,
  output logic        o_v_aync_m,
  output logic        o_v_aync_s,
  output logic [23:0] o_data_m,
  output logic [23:0] o_data_s,
  output logic        o_remainder_signal_m,
  output logic        o_remainder_signal_s
);

  localparam int NW    = (P_IMAGE_WIDTH + 2) / 3;
  localparam int R     = P_IMAGE_WIDTH % 3;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int DEPTH = 3 * NW;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {B_IDLE, B_ARM, B_RUN} burst_t;

  logic          h_d, v_d;
  logic [11:0]   col;
  logic [1:0]    pos;
  logic [IW-1:0] widx;
  logic          pend;
  logic [7:0]    b0, b1;
  logic          frame_act;
  logic [11:0]   row_cnt;
  logic [1:0]    wr_sel, m_sel, s_sel;
  logic          row_zero;
  burst_t        bstate;
  logic [IW-1:0] bcnt;

  logic [23:0]   mem [DEPTH];

  logic          row_end, v_rise, pix_ok, last_pix, wr_ok;
  logic [11:0]   col_eff;
  logic [1:0]    pos_eff;
  logic [IW-1:0] widx_eff, wr_idx;
  logic          we;
  logic [23:0]   wdata;
  logic [AW-1:0] waddr, m_addr, s_addr;

  function automatic logic [AW-1:0] base(input logic [1:0] sel);
    base = AW'(sel) * AW'(NW);
  endfunction

  assign row_end  = h_d && !i_h_aync;
  assign v_rise   = i_v_aync && !v_d;
  // The first pixel of a row (rising edge of i_h_aync) sees cleared counters.
  assign col_eff  = h_d ? col  : '0;
  assign pos_eff  = h_d ? pos  : '0;
  assign widx_eff = h_d ? widx : '0;
  assign pix_ok   = i_h_aync && (col_eff < 12'(P_IMAGE_WIDTH));
  assign last_pix = (col_eff == 12'(P_IMAGE_WIDTH - 1));
  assign wr_ok    = frame_act && (row_cnt < 12'(P_IMAGE_HEIGHT));

  always_comb begin
    we     = 1'b0;
    wr_idx = widx_eff;
    wdata  = '0;
    if (pix_ok) begin
      case (pos_eff)
        2'd0: begin we = last_pix; wdata = {i_data, 16'h0000}; end
        2'd1: begin we = last_pix; wdata = {b0, i_data, 8'h00}; end
        2'd2: begin we = 1'b1;     wdata = {b0, b1, i_data};   end
        default: ;
      endcase
    end else if (row_end && pend) begin
      // Short row: flush the partially filled word, zero-padded.
      we     = 1'b1;
      wr_idx = widx;
      wdata  = {b0, (pos == 2'd2) ? b1 : 8'h00, 8'h00};
    end
    we = we && wr_ok;
  end

  assign waddr  = base(wr_sel) + AW'(wr_idx);
  assign m_addr = base(m_sel)  + AW'(bcnt);
  assign s_addr = base(s_sel)  + AW'(bcnt);

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_d        <= 1'b0;
      // Held high so a frame already in progress at release is not taken as a start.
      v_d        <= 1'b1;
      col        <= '0;
      pos        <= '0;
      widx       <= '0;
      pend       <= 1'b0;
      b0         <= '0;
      b1         <= '0;
      frame_act  <= 1'b0;
      row_cnt    <= '0;
      wr_sel     <= 2'd0;
      m_sel      <= 2'd1;
      s_sel      <= 2'd2;
      row_zero   <= 1'b1;
      bstate     <= B_IDLE;
      bcnt       <= '0;
      o_h_aync_m <= 1'b0;
      o_v_aync_m <= 1'b0;
      o_data_m   <= '0;
      o_data_s   <= '0;
      o_remainder_signal_m <= 1'b0;
    end else begin
      h_d <= i_h_aync;
      v_d <= i_v_aync;

      if (pix_ok) begin
        col <= col_eff + 12'd1;
        case (pos_eff)
          2'd0: begin b0 <= i_data; pend <= !last_pix; pos <= 2'd1; widx <= widx_eff; end
          2'd1: begin b1 <= i_data; pend <= !last_pix; pos <= 2'd2; widx <= widx_eff; end
          default: begin pend <= 1'b0; pos <= 2'd0; widx <= widx_eff + IW'(1); end
        endcase
      end
      if (row_end) pend <= 1'b0;

      case (bstate)
        B_IDLE: begin
          o_h_aync_m <= 1'b0;
          o_data_m   <= '0;
          o_data_s   <= '0;
          o_remainder_signal_m <= 1'b0;
          if (row_end && wr_ok) begin
            // Written buffer becomes m, old m becomes s, old s is reused for writing.
            wr_sel   <= s_sel;
            m_sel    <= wr_sel;
            s_sel    <= m_sel;
            row_zero <= (row_cnt == '0);
            row_cnt  <= row_cnt + 12'd1;
            bstate   <= B_ARM;
          end else if (!frame_act || row_cnt == 12'(P_IMAGE_HEIGHT)) begin
            o_v_aync_m <= 1'b0;
          end
        end
        B_ARM: begin
          bcnt   <= '0;
          bstate <= B_RUN;
        end
        B_RUN: begin
          o_h_aync_m <= 1'b1;
          o_v_aync_m <= 1'b1;
          o_data_m   <= mem[m_addr];
          o_data_s   <= row_zero ? '0 : mem[s_addr];
          o_remainder_signal_m <= (bcnt == IW'(NW - 1)) && (R != 0);
          bcnt <= bcnt + IW'(1);
          if (bcnt == IW'(NW - 1)) bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase

      if (v_rise) begin
        frame_act <= 1'b1;
        row_cnt   <= '0;
      end else if (!i_v_aync) begin
        frame_act <= 1'b0;
      end
    end
  end

  assign o_h_aync_s           = o_h_aync_m;
  assign o_v_aync_s           = o_v_aync_m;
  assign o_remainder_signal_s = o_remainder_signal_m;

endmodule
